// File: rtl/rv_li_encoder.sv
// Expands a (32-bit constant, rd) request into the RV32I "li rd, value" sequence
// (LUI and/or ADDI, or a NOP for rd == x0) on a valid/ready instruction stream.
module rv_li_encoder #(
    parameter bit OPT_SHORT = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] value_i,
    input  logic [4:0]  rd_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic        instr_last_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        EMIT_LUI,
        EMIT_ADDI
    } state_t;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;
    localparam logic [6:0]  OP_LUI   = 7'b0110111;
    localparam logic [6:0]  OP_IMM   = 7'b0010011;

    state_t      state;
    logic        pair;
    logic [31:0] pending;

    logic [11:0] lo;
    logic [19:0] hi;
    logic        fits_imm12;
    logic        lo_zero;
    logic        rd_zero;
    logic [31:0] lui_word;
    logic [31:0] addi_x0_word;
    logic [31:0] addi_rd_word;
    logic        accept;
    logic        fire;

    // hi absorbs the carry from the sign-extended ADDI immediate
    always_comb begin
        lo           = value_i[11:0];
        hi           = value_i[31:12] + {19'd0, value_i[11]};
        fits_imm12   = (value_i[31:11] == '0) || (value_i[31:11] == '1);
        lo_zero      = (lo == '0);
        rd_zero      = (rd_i == '0);
        lui_word     = {hi, rd_i, OP_LUI};
        addi_x0_word = {lo, 5'd0, 3'b000, rd_i, OP_IMM};
        addi_rd_word = {lo, rd_i, 3'b000, rd_i, OP_IMM};
    end

    assign accept = req_valid_i && req_ready_o;
    assign fire   = instr_valid_o && instr_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            pair          <= 1'b0;
            pending       <= '0;
            req_ready_o   <= 1'b1;
            instr_valid_o <= 1'b0;
            instr_o       <= '0;
            instr_last_o  <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_ready_o   <= 1'b0;
                        busy_o        <= 1'b1;
                        instr_valid_o <= 1'b1;
                        pending       <= addi_rd_word;
                        if (rd_zero) begin
                            instr_o      <= NOP_WORD;
                            instr_last_o <= 1'b1;
                            pair         <= 1'b0;
                            state        <= EMIT_ADDI;
                        end else if (OPT_SHORT && fits_imm12) begin
                            instr_o      <= addi_x0_word;
                            instr_last_o <= 1'b1;
                            pair         <= 1'b0;
                            state        <= EMIT_ADDI;
                        end else if (OPT_SHORT && lo_zero) begin
                            instr_o      <= lui_word;
                            instr_last_o <= 1'b1;
                            pair         <= 1'b0;
                            state        <= EMIT_LUI;
                        end else begin
                            instr_o      <= lui_word;
                            instr_last_o <= 1'b0;
                            pair         <= 1'b1;
                            state        <= EMIT_LUI;
                        end
                    end
                end

                EMIT_LUI: begin
                    if (fire) begin
                        if (pair) begin
                            instr_o      <= pending;
                            instr_last_o <= 1'b1;
                            state        <= EMIT_ADDI;
                        end else begin
                            instr_valid_o <= 1'b0;
                            instr_o       <= '0;
                            instr_last_o  <= 1'b0;
                            busy_o        <= 1'b0;
                            req_ready_o   <= 1'b1;
                            state         <= IDLE;
                        end
                    end
                end

                EMIT_ADDI: begin
                    if (fire) begin
                        instr_valid_o <= 1'b0;
                        instr_o       <= '0;
                        instr_last_o  <= 1'b0;
                        busy_o        <= 1'b0;
                        req_ready_o   <= 1'b1;
                        state         <= IDLE;
                    end
                end

                default: begin
                    instr_valid_o <= 1'b0;
                    instr_o       <= '0;
                    instr_last_o  <= 1'b0;
                    busy_o        <= 1'b0;
                    req_ready_o   <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_li_encoder.sv
// Bench for rv_li_encoder: both OPT_SHORT settings side by side, fixed vectors,
// timing/backpressure/reset sequences and randomized requests against a reference model.
module tb_rv_li_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] value = '0;
    logic [4:0]  rd = '0;
    logic        instr_ready = 1'b0;

    logic        ready_s, valid_s, last_s, busy_s;
    logic [31:0] instr_s;
    logic        ready_f, valid_f, last_f, busy_f;
    logic [31:0] instr_f;

    always #5 clk = ~clk;

    rv_li_encoder #(.OPT_SHORT(1'b1)) u_short (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(ready_s),
        .value_i(value), .rd_i(rd), .instr_valid_o(valid_s), .instr_ready_i(instr_ready),
        .instr_o(instr_s), .instr_last_o(last_s), .busy_o(busy_s)
    );

    rv_li_encoder #(.OPT_SHORT(1'b0)) u_full (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(ready_f),
        .value_i(value), .rd_i(rd), .instr_valid_o(valid_f), .instr_ready_i(instr_ready),
        .instr_o(instr_f), .instr_last_o(last_f), .busy_o(busy_f)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Accepted words {last, word} per instance, plus a hold check under backpressure
    logic [32:0] qs[$];
    logic [32:0] qf[$];
    bit          stall_s = 0, stall_f = 0;
    logic [32:0] held_s, held_f;

    always @(negedge clk) begin
        if (rst) begin
            stall_s = 0;
            stall_f = 0;
        end else begin
            if (stall_s) chk("hold_short", {valid_s, last_s, instr_s[29:0]}, {1'b1, held_s[32], held_s[29:0]});
            if (stall_f) chk("hold_full", {valid_f, last_f, instr_f[29:0]}, {1'b1, held_f[32], held_f[29:0]});
            if (valid_s && instr_ready) qs.push_back({last_s, instr_s});
            if (valid_f && instr_ready) qf.push_back({last_f, instr_f});
            stall_s = valid_s && !instr_ready;
            stall_f = valid_f && !instr_ready;
            held_s  = {last_s, instr_s};
            held_f  = {last_f, instr_f};
        end
    end

    // Reference: li expansion from signed-range arithmetic on the whole value
    task automatic model(input logic [31:0] v, input logic [4:0] r, input bit opt,
                         output int n, output logic [31:0] w0, output logic [31:0] w1);
        int          sv;
        logic [31:0] rounded;
        logic [31:0] lui;
        sv      = $signed(v);
        rounded = v + 32'h0000_0800;
        lui     = (rounded & 32'hFFFF_F000) | (32'(r) << 7) | 32'h37;
        w1      = '0;
        if (r == 5'd0) begin
            n  = 1;
            w0 = 32'h0000_0013;
        end else if (opt && sv >= -2048 && sv <= 2047) begin
            n  = 1;
            w0 = ((v & 32'hFFF) << 20) | (32'(r) << 7) | 32'h13;
        end else if (opt && (v % 4096) == 0) begin
            n  = 1;
            w0 = lui;
        end else begin
            n  = 2;
            w0 = lui;
            w1 = ((v & 32'hFFF) << 20) | (32'(r) << 15) | (32'(r) << 7) | 32'h13;
        end
    endtask

    task automatic check_exp(input string tag, input bit opt, input int n,
                             input logic [31:0] w0, input logic [31:0] w1);
        logic [32:0] q[$];
        if (opt) q = qs;
        else     q = qf;
        chk({tag, "_count"}, q.size(), n);
        for (int i = 0; i < n && i < q.size(); i++) begin
            chk($sformatf("%s_word%0d", tag, i), q[i][31:0], (i == 0) ? w0 : w1);
            chk($sformatf("%s_last%0d", tag, i), 32'(q[i][32]), 32'(i == n - 1));
        end
    endtask

    task automatic run_req(input logic [31:0] v, input logic [4:0] r, input bit rnd_ready);
        bit ok;
        qs.delete();
        qf.delete();
        @(posedge clk); #1;
        req_valid   = 1'b1;
        value       = v;
        rd          = r;
        instr_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ready_s && ready_f) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        value     = $urandom;
        rd        = 5'($urandom);
        ok = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (!busy_s && !busy_f && !valid_s && !valid_f) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
            if (rnd_ready) instr_ready = ($urandom_range(0, 3) != 0);
        end
        if (!ok) chk("drain_timeout", 32'd0, 32'd1);
        instr_ready = 1'b1;
    endtask

    typedef struct {
        logic [31:0] value;
        logic [4:0]  rd;
        int          ns;
        logic [31:0] s0, s1;
        int          nf;
        logic [31:0] f0, f1;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int          n;
        logic [31:0] w0, w1, v, tmp;
        logic [11:0] t12;
        logic [4:0]  r;

        vecs[0] = '{32'h12345678, 5'd10, 2, 32'h12345537, 32'h67850513, 2, 32'h12345537, 32'h67850513};
        vecs[1] = '{32'h12345FFF, 5'd1,  2, 32'h123460B7, 32'hFFF08093, 2, 32'h123460B7, 32'hFFF08093};
        vecs[2] = '{32'hFFFFF800, 5'd5,  1, 32'h80000293, 32'h0,        2, 32'h000002B7, 32'h80028293};
        vecs[3] = '{32'h00010000, 5'd2,  1, 32'h00010137, 32'h0,        2, 32'h00010137, 32'h00010113};
        vecs[4] = '{32'h00000005, 5'd0,  1, 32'h00000013, 32'h0,        1, 32'h00000013, 32'h0};
        vecs[5] = '{32'h000007FF, 5'd3,  1, 32'h7FF00193, 32'h0,        2, 32'h000001B7, 32'h7FF18193};
        vecs[6] = '{32'h00000800, 5'd4,  2, 32'h00001237, 32'h80020213, 2, 32'h00001237, 32'h80020213};

        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(valid_s), 32'd0);
        chk("rst_instr", instr_s, 32'd0);
        chk("rst_last",  32'(last_s), 32'd0);
        chk("rst_busy",  32'(busy_s), 32'd0);
        chk("rst_ready", 32'(ready_s), 32'd1);
        chk("rst_valid_full", 32'(valid_f), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (vecs[k]) begin
            run_req(vecs[k].value, vecs[k].rd, 1'b0);
            check_exp($sformatf("vec%0d_s", k), 1'b1, vecs[k].ns, vecs[k].s0, vecs[k].s1);
            check_exp($sformatf("vec%0d_f", k), 1'b0, vecs[k].nf, vecs[k].f0, vecs[k].f1);
        end

        // Cycle-exact pair timing with the consumer always ready
        instr_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b1; value = 32'h12345678; rd = 5'd10;
        @(negedge clk);
        chk("t_ready_idle", 32'(ready_s), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; value = 32'hDEADBEEF; rd = 5'd7;
        @(negedge clk);
        chk("t_w0_valid", 32'(valid_s), 32'd1);
        chk("t_w0_instr", instr_s, 32'h12345537);
        chk("t_w0_last",  32'(last_s), 32'd0);
        chk("t_w0_ready", 32'(ready_s), 32'd0);
        chk("t_w0_busy",  32'(busy_s), 32'd1);
        @(negedge clk);
        chk("t_w1_instr", instr_s, 32'h67850513);
        chk("t_w1_last",  32'(last_s), 32'd1);
        chk("t_w1_ready", 32'(ready_s), 32'd0);
        @(negedge clk);
        chk("t_end_valid", 32'(valid_s), 32'd0);
        chk("t_end_instr", instr_s, 32'd0);
        chk("t_end_last",  32'(last_s), 32'd0);
        chk("t_end_ready", 32'(ready_s), 32'd1);
        chk("t_end_busy",  32'(busy_s), 32'd0);

        // Backpressure on the first word of a pair, then reset mid-expansion
        @(posedge clk); #1;
        instr_ready = 1'b0;
        req_valid = 1'b1; value = 32'h12345FFF; rd = 5'd1;
        @(posedge clk); #1;
        req_valid = 1'b0; value = 32'h0; rd = 5'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(valid_s), 32'd1);
            chk("bp_instr", instr_s, 32'h123460B7);
            chk("bp_last",  32'(last_s), 32'd0);
            chk("bp_instr_full", instr_f, 32'h123460B7);
        end
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(valid_s), 32'd0);
        chk("mid_rst_instr", instr_s, 32'd0);
        chk("mid_rst_busy",  32'(busy_s), 32'd0);
        chk("mid_rst_ready", 32'(ready_s), 32'd1);
        chk("mid_rst_valid_full", 32'(valid_f), 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        instr_ready = 1'b1;
        run_req(32'h12345678, 5'd10, 1'b0);
        check_exp("post_rst_s", 1'b1, 2, 32'h12345537, 32'h67850513);
        check_exp("post_rst_f", 1'b0, 2, 32'h12345537, 32'h67850513);

        // Randomized requests with random consumer stalls
        for (int t = 0; t < 150; t++) begin
            tmp = $urandom;
            case ($urandom_range(0, 3))
                0: v = tmp;
                1: begin t12 = tmp[11:0]; v = {{20{t12[11]}}, t12}; end
                2: v = {tmp[31:12], 12'h000};
                default: v = tmp | 32'h0000_0800;
            endcase
            r = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            run_req(v, r, 1'b1);
            model(v, r, 1'b1, n, w0, w1);
            check_exp($sformatf("rnd%0d_s", t), 1'b1, n, w0, w1);
            model(v, r, 1'b0, n, w0, w1);
            check_exp($sformatf("rnd%0d_f", t), 1'b0, n, w0, w1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
